// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline stall/flush/forwarding control with a multi-cycle MDU freeze FSM
module hazard_control_unit #(
  parameter int MDU_LAT = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic [4:0]       ex_rs_i,
  input  logic [4:0]       ex_rt_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_memread_i,
  input  logic             ex_mdu_start_i,
  input  logic             ex_branch_taken_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_regwrite_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_regwrite_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_en_o,
  output logic             idex_bubble_o,
  output logic             exmem_bubble_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             mdu_busy_o,
  output logic [CNT_W-1:0] stall_cycles_o
);
  localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  typedef enum logic {RUN, MDU_WAIT} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use;
  assign fwd_a_o = (mem_regwrite_i && mem_rd_i != 5'd0 && mem_rd_i == ex_rs_i) ? 2'b01 :
                   (wb_regwrite_i && wb_rd_i != 5'd0 && wb_rd_i == ex_rs_i) ? 2'b10 : 2'b00;
  assign fwd_b_o = (mem_regwrite_i && mem_rd_i != 5'd0 && mem_rd_i == ex_rt_i) ? 2'b01 :
                   (wb_regwrite_i && wb_rd_i != 5'd0 && wb_rd_i == ex_rt_i) ? 2'b10 : 2'b00;
  assign load_use = ex_memread_i && ex_regwrite_i && ex_rd_i != 5'd0 &&
                    ((id_uses_rs_i && ex_rd_i == id_rs_i) || (id_uses_rt_i && ex_rd_i == id_rt_i));
  assign stall_d = (!pc_en_o && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
  assign stall_cycles_o = stall_q;
  // MDU freeze takes precedence, then taken branch (squashes any load-use victim), then load-use
  always_comb begin
    state_d        = state_q;
    mdu_cnt_d      = mdu_cnt_q;
    pc_en_o        = 1'b1;
    ifid_en_o      = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_en_o      = 1'b1;
    idex_bubble_o  = 1'b0;
    exmem_bubble_o = 1'b0;
    mdu_busy_o     = 1'b0;
    if (state_q == MDU_WAIT) begin
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      idex_en_o      = 1'b0;
      mdu_busy_o     = 1'b1;
      exmem_bubble_o = mdu_cnt_q != '0;
      state_d        = (mdu_cnt_q == '0) ? RUN : MDU_WAIT;
      mdu_cnt_d      = (mdu_cnt_q == '0) ? mdu_cnt_q : mdu_cnt_q - CW'(1);
    end else if (ex_mdu_start_i) begin
      state_d        = MDU_WAIT;
      mdu_cnt_d      = CW'(MDU_LAT - 2);
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      idex_en_o      = 1'b0;
      exmem_bubble_o = 1'b1;
    end else if (ex_branch_taken_i) begin
      ifid_flush_o   = 1'b1;
      idex_bubble_o  = 1'b1;
    end else if (load_use) begin
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      idex_bubble_o  = 1'b1;
    end
  end
  // State, MDU countdown and saturating stall counter; reset aborts any MDU op
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= RUN;
      mdu_cnt_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
      stall_q   <= stall_d;
    end
  end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed vectors with a queued scoreboard checked at negedge
module tb_hazard_control_unit;
  typedef struct packed {
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rs, id_uses_rt;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic       ex_regwrite, ex_memread, ex_mdu_start, ex_branch_taken;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic [4:0] wb_rd;
    logic       wb_regwrite;
  } in_t;
  typedef struct {
    string       nm;
    logic [10:0] c;
    logic [15:0] s;
  } exp_t;
  // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, fwd_a, fwd_b, mdu_busy}
  localparam logic [10:0] N  = 11'b110100_0000_0;
  localparam logic [10:0] LU = 11'b000110_0000_0;
  localparam logic [10:0] BR = 11'b111110_0000_0;
  localparam logic [10:0] MF = 11'b000001_0000_0;
  localparam logic [10:0] MW = 11'b000001_0000_1;
  localparam logic [10:0] ML = 11'b000000_0000_1;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  in_t         vi = '0;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, mdu_busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall;
  exp_t        q[$];
  int          pass = 0;
  int          total = 0;
  hazard_control_unit #(.MDU_LAT(8), .CNT_W(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .id_rs_i(vi.id_rs), .id_rt_i(vi.id_rt), .id_uses_rs_i(vi.id_uses_rs), .id_uses_rt_i(vi.id_uses_rt),
    .ex_rs_i(vi.ex_rs), .ex_rt_i(vi.ex_rt), .ex_rd_i(vi.ex_rd),
    .ex_regwrite_i(vi.ex_regwrite), .ex_memread_i(vi.ex_memread),
    .ex_mdu_start_i(vi.ex_mdu_start), .ex_branch_taken_i(vi.ex_branch_taken),
    .mem_rd_i(vi.mem_rd), .mem_regwrite_i(vi.mem_regwrite),
    .wb_rd_i(vi.wb_rd), .wb_regwrite_i(vi.wb_regwrite),
    .pc_en_o(pc_en), .ifid_en_o(ifid_en), .ifid_flush_o(ifid_flush), .idex_en_o(idex_en),
    .idex_bubble_o(idex_bubble), .exmem_bubble_o(exmem_bubble),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .mdu_busy_o(mdu_busy), .stall_cycles_o(stall)
  );
  always #5 clk_i = ~clk_i;
  task automatic step(input in_t v, input logic r, input string nm, input logic [10:0] c, input logic [15:0] s);
    @(posedge clk_i);
    #1;
    reset_i = r;
    vi = v;
    q.push_back('{nm, c, s});
  endtask
  always @(negedge clk_i) begin : monitor
    exp_t e;
    logic [10:0] got;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, fwd_a, fwd_b, mdu_busy};
      total++;
      if (got === e.c && stall === e.s) pass++;
      else $display("FAIL %s: got ctl=%b stall=%0d, want ctl=%b stall=%0d", e.nm, got, stall, e.c, e.s);
    end
  end
  initial begin
    in_t v, lu, vm;
    lu = '0;
    lu.ex_memread = 1'b1; lu.ex_regwrite = 1'b1; lu.ex_rd = 5'd5; lu.id_uses_rs = 1'b1; lu.id_rs = 5'd5;
    step('0, 1'b1, "reset", N, 16'd0);
    step('0, 1'b0, "idle", N, 16'd0);
    step(lu, 1'b0, "load_use_rs", LU, 16'd0);
    v = '0; v.mem_rd = 5'd5; v.mem_regwrite = 1'b1; v.ex_rs = 5'd5;
    step(v, 1'b0, "after_load_fwd", N | 11'b000000_01_00_0, 16'd1);
    v = '0; v.mem_rd = 5'd3; v.mem_regwrite = 1'b1; v.wb_rd = 5'd3; v.wb_regwrite = 1'b1; v.ex_rs = 5'd3;
    step(v, 1'b0, "fwd_mem_beats_wb", N | 11'b000000_01_00_0, 16'd1);
    v = '0; v.wb_rd = 5'd3; v.wb_regwrite = 1'b1; v.ex_rs = 5'd3; v.ex_rt = 5'd3;
    step(v, 1'b0, "fwd_wb_both", N | 11'b000000_10_10_0, 16'd1);
    v = '0; v.mem_rd = 5'd4; v.mem_regwrite = 1'b1; v.wb_rd = 5'd9; v.wb_regwrite = 1'b1; v.ex_rs = 5'd9; v.ex_rt = 5'd4;
    step(v, 1'b0, "fwd_mixed", N | 11'b000000_10_01_0, 16'd1);
    v = '0; v.mem_regwrite = 1'b1; v.wb_regwrite = 1'b1;
    step(v, 1'b0, "fwd_r0", N, 16'd1);
    v = lu; v.ex_rd = 5'd0; v.id_rs = 5'd0;
    step(v, 1'b0, "load_use_r0", N, 16'd1);
    v = '0; v.ex_memread = 1'b1; v.ex_regwrite = 1'b1; v.ex_rd = 5'd7; v.id_rt = 5'd7;
    step(v, 1'b0, "rt_not_used", N, 16'd1);
    v.id_uses_rt = 1'b1;
    step(v, 1'b0, "load_use_rt", LU, 16'd1);
    v.ex_regwrite = 1'b0;
    step(v, 1'b0, "memread_no_write", N, 16'd2);
    v = lu; v.ex_branch_taken = 1'b1;
    step(v, 1'b0, "branch_over_load_use", BR, 16'd2);
    v = '0; v.ex_branch_taken = 1'b1;
    step(v, 1'b0, "branch", BR, 16'd2);
    vm = lu; vm.ex_branch_taken = 1'b1; vm.ex_mdu_start = 1'b1;
    step(vm, 1'b0, "mdu_start", MF, 16'd2);
    for (int i = 0; i < 6; i++) step(vm, 1'b0, "mdu_wait", MW, 16'(3 + i));
    step(vm, 1'b0, "mdu_last", ML, 16'd9);
    step('0, 1'b0, "mdu_done", N, 16'd10);
    v = '0; v.ex_mdu_start = 1'b1;
    step(v, 1'b0, "mdu2_start", MF, 16'd10);
    step(v, 1'b0, "mdu2_wait1", MW, 16'd11);
    step(v, 1'b0, "mdu2_wait2", MW, 16'd12);
    step('0, 1'b1, "reset_mid_mdu", N, 16'd0);
    step('0, 1'b0, "post_reset", N, 16'd0);
    step(lu, 1'b0, "sat_start", LU, 16'd0);
    repeat (65533) @(posedge clk_i);
    step(lu, 1'b0, "sat_fffe", LU, 16'hFFFE);
    step(lu, 1'b0, "sat_ffff", LU, 16'hFFFF);
    step(lu, 1'b0, "sat_hold", LU, 16'hFFFF);
    repeat (5) @(posedge clk_i);
    step('0, 1'b0, "sat_no_wrap", N, 16'hFFFF);
    repeat (2) @(posedge clk_i);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
